hazard_freeze_controller: RTL and testbench
===========================================

Name: hazard_freeze_controller

Overview:
- Central pipeline sequencer for the five-stage ARM core with data cache.
- Produces the `hazard` stall input consumed by the decode stage, from RAW dependencies against the EXE and MEM destinations.
- Freezes the whole pipeline while the cache is serving a miss, and flushes IF/ID on taken branches.
- Keeps saturating stall/hazard performance counters and a cache-miss watchdog.

Parameters:
- MISS_TIMEOUT, 255: max consecutive MEM_WAIT cycles before the ERROR state.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- src1  in  4  decode first source register (Rn field)
- src2  in  4  decode second source register (Rm, or Rd for stores)
- two_src  in  1  src2 is a real operand
- exe_wb_en  in  1  EXE-stage instruction writes the register file
- exe_dest  in  4  EXE-stage destination
- exe_mem_r_en  in  1  EXE-stage instruction is a load
- mem_wb_en  in  1  MEM-stage instruction writes the register file
- mem_dest  in  4  MEM-stage destination
- forward_en  in  1  forwarding unit active
- branch_taken  in  1  EXE-stage branch resolved taken
- mem_access  in  1  MEM-stage read or write request to the cache
- cache_ready  in  1  cache has completed the current access
- clr_counters  in  1  synchronous clear of the performance counters
- hazard  out  1  decode-stage stall: freeze PC and IF/ID, bubble into EXE
- freeze  out  1  freeze all pipeline registers
- flush  out  1  clear the IF/ID register
- mem_timeout  out  1  sticky watchdog error flag
- state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR
- stall_cycles  out  CNT_W  count of cycles with `freeze` high
- hazard_cycles  out  CNT_W  count of cycles with `hazard` high

Behaviour:
- Reset (async) values:
  - state=RUN, wait counter=0.
  - mem_timeout=0, stall_cycles=0, hazard_cycles=0.
  - Combinational outputs evaluate from inputs with state=RUN.
- RAW match rules:
  - m1 = src1 equals dest and wb_en.
  - m2 = two_src and src2 equals dest and wb_en.
  - Both rules apply to the EXE and MEM stages.
  - Register 15 (PC) is compared like any other register; there is no special case.
- raw:
  - forward_en=0: raw = any EXE match or any MEM match.
  - forward_en=1: raw = exe_mem_r_en and an EXE match (load-use only).
- freeze:
  - Asserted when state is MEM_WAIT or ERROR.
  - In RUN it is Mealy: asserted when mem_access=1 and cache_ready=0.
- hazard = raw and not freeze and not branch_taken.
- flush = branch_taken and not freeze.
  - A branch taken during a freeze is held by the frozen EXE register, so flush fires on the first unfrozen cycle.
- Priority: freeze > flush > hazard. Only one of these outputs is high in any cycle.
- FSM, evaluated on the rising edge:
  - RUN → MEM_WAIT when mem_access=1 and cache_ready=0; the wait counter loads 1.
  - MEM_WAIT → RUN when cache_ready=1. In that same cycle freeze drops (Mealy exit: freeze = not cache_ready in MEM_WAIT), so the pipeline advances on that edge.
  - MEM_WAIT otherwise: wait counter +1. When the counter reaches MISS_TIMEOUT with cache_ready still 0, go to ERROR.
  - ERROR: freeze=1 and mem_timeout=1 are held until rst; all other inputs are ignored.
  - mem_access falling while in MEM_WAIT is illegal; the block stays in MEM_WAIT until cache_ready.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones.
  - clr_counters clears both counters synchronously and has priority over increment.
  - A qualifying cycle coincident with clr_counters is not counted.
  - Counters keep counting in ERROR (freeze=1).
- Reset mid-miss: returns to RUN immediately with counters and the flag cleared. The cache is reset by the same rst.

Test Plan:
- No forwarding:
  - src1=3, exe_dest=3, exe_wb_en=1, two_src=0 → hazard=1, freeze=0, flush=0.
  - Same stimulus with exe_wb_en=0 → hazard=0.
- two_src gating: src2=5, mem_dest=5, mem_wb_en=1.
  - two_src=0 → hazard=0.
  - two_src=1, forward_en=0 → hazard=1.
  - two_src=1, forward_en=1 → hazard=0.
- Load-use: forward_en=1, exe_mem_r_en=1, exe_dest=2, src1=2 → hazard=1. Dropping exe_mem_r_en → hazard=0.
- Cache miss:
  - mem_access=1, cache_ready=0 for 4 cycles, then 1 → freeze high for exactly 4 cycles.
  - state sequence RUN, MEM_WAIT×3, RUN; stall_cycles=4.
  - A coincident branch_taken=1 gives flush=0 during the freeze and flush=1 on the release cycle.
- Watchdog: MISS_TIMEOUT=8, cache_ready held 0 → state=ERROR after cycle 8, mem_timeout=1 and freeze=1 persist; async rst mid-cycle → all outputs return to reset values.
- Counters: CNT_W=4, hazard held 20 cycles → hazard_cycles saturates at 15. clr_counters pulse → 0 next cycle.

Source files
------------

// File: rtl/hazard_freeze_controller.sv
// Pipeline sequencer for the five-stage core. It raises the decode-stage hazard
// stall, freezes the pipeline on cache misses, flushes IF/ID on taken branches,
// and keeps stall/hazard performance counters plus a cache-miss watchdog.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; a cache miss freezes the pipeline combinationally
// MEM_WAIT | cache serving a miss; freeze is held until cache_ready
// ERROR    | miss watchdog expired; freeze and mem_timeout held until rst
module hazard_freeze_controller #(
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             cache_ready,
  input  logic             clr_counters,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] hazard_cycles
);

  localparam int WAIT_W = (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MISS_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              freeze_c;
  logic              exe_match, mem_match, raw;

  // RAW detection; r15 is treated as an ordinary register.
  always_comb begin
    exe_match = exe_wb_en && ((src1 == exe_dest) || (two_src && (src2 == exe_dest)));
    mem_match = mem_wb_en && ((src1 == mem_dest) || (two_src && (src2 == mem_dest)));
    if (forward_en) raw = exe_mem_r_en && exe_match;
    else            raw = exe_match || mem_match;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    freeze_c  = 1'b0;
    case (state_q)
      RUN: begin
        freeze_c = mem_access && !cache_ready;
        if (freeze_c) begin
          wait_d = WAIT_W'(1);
          if (WAIT_LIMIT <= WAIT_W'(1)) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        // Exit is Mealy: freeze drops in the cycle cache_ready arrives.
        freeze_c = !cache_ready;
        if (cache_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d == WAIT_LIMIT) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end
        end
      end
      ERROR: begin
        freeze_c  = 1'b1;
        timeout_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  assign freeze      = freeze_c;
  assign flush       = branch_taken && !freeze_c;
  assign hazard      = raw && !freeze_c && !branch_taken;
  assign mem_timeout = timeout_q;
  assign state       = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles  <= '0;
      hazard_cycles <= '0;
    end else if (clr_counters) begin
      stall_cycles  <= '0;
      hazard_cycles <= '0;
    end else begin
      if (freeze_c && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (hazard && (hazard_cycles != '1))
        hazard_cycles <= hazard_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_freeze_controller.sv
// Directed bench for hazard_freeze_controller: a table of combinational
// vectors plus hand-written miss, watchdog, reset and counter sequences.
module tb_hazard_freeze_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic       two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, forward_en;
  logic       branch_taken, mem_access, cache_ready, clr_counters;
  logic       hazard, freeze, flush, mem_timeout;
  logic [1:0] state;
  logic [3:0] stall_cycles, hazard_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_freeze_controller #(.MISS_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .forward_en(forward_en),
    .branch_taken(branch_taken), .mem_access(mem_access),
    .cache_ready(cache_ready), .clr_counters(clr_counters),
    .hazard(hazard), .freeze(freeze), .flush(flush),
    .mem_timeout(mem_timeout), .state(state),
    .stall_cycles(stall_cycles), .hazard_cycles(hazard_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic       two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, forward_en;
    logic       branch_taken, mem_access, cache_ready;
    logic       exp_hazard, exp_freeze, exp_flush;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(string name, logic [3:0] s1, logic [3:0] s2,
                              logic two, logic ewb, logic [3:0] ed, logic eld,
                              logic mwb, logic [3:0] md, logic fwd, logic bt,
                              logic ma, logic cr, logic eh, logic efz, logic efl);
    vec_t v;
    v.name = name; v.src1 = s1; v.src2 = s2; v.two_src = two;
    v.exe_wb_en = ewb; v.exe_dest = ed; v.exe_mem_r_en = eld;
    v.mem_wb_en = mwb; v.mem_dest = md; v.forward_en = fwd;
    v.branch_taken = bt; v.mem_access = ma; v.cache_ready = cr;
    v.exp_hazard = eh; v.exp_freeze = efz; v.exp_flush = efl;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    src1 = 4'd0; src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
    two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
    forward_en = 1'b0; branch_taken = 1'b0; mem_access = 1'b0;
    cache_ready = 1'b0; clr_counters = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        name        s1 s2 two ewb ed eld mwb md fwd bt ma cr  h fz fl
    vecs[0]  = mk("raw_exe",      3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk("exe_no_wb",    3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk("src2_gated",   0, 5, 0, 0, 9, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk("src2_mem",     0, 5, 1, 0, 9, 0, 1, 5, 0, 0, 0, 0, 1, 0, 0);
    vecs[4]  = mk("src2_fwd",     0, 5, 1, 0, 9, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk("load_use",     2, 0, 0, 1, 2, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    vecs[6]  = mk("no_load",      2, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk("branch_prio",  3, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    vecs[8]  = mk("r15_raw",     15, 0, 0, 1,15, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[9]  = mk("load_src2",    0, 4, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    vecs[10] = mk("fwd_mem_only", 7, 0, 0, 0, 9, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk("cache_hit",    0, 0, 0, 0, 9, 0, 0, 9, 0, 0, 1, 1, 0, 0, 0);

    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_stall_cnt", stall_cycles, 0);
    chk("rst_hazard_cnt", hazard_cycles, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_flush", flush, 0);
    #20;
    rst = 1'b0;

    // Combinational vector table, all applied in RUN.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      src1 = vecs[i].src1; src2 = vecs[i].src2; two_src = vecs[i].two_src;
      exe_wb_en = vecs[i].exe_wb_en; exe_dest = vecs[i].exe_dest;
      exe_mem_r_en = vecs[i].exe_mem_r_en; mem_wb_en = vecs[i].mem_wb_en;
      mem_dest = vecs[i].mem_dest; forward_en = vecs[i].forward_en;
      branch_taken = vecs[i].branch_taken; mem_access = vecs[i].mem_access;
      cache_ready = vecs[i].cache_ready;
      @(negedge clk);
      chk({vecs[i].name, "_hazard"}, hazard, vecs[i].exp_hazard);
      chk({vecs[i].name, "_freeze"}, freeze, vecs[i].exp_freeze);
      chk({vecs[i].name, "_flush"},  flush,  vecs[i].exp_flush);
      chk({vecs[i].name, "_state"},  state,  0);
    end

    // Cache miss of four frozen cycles with a branch held in EXE.
    next_cycle();
    idle_inputs();
    clr_counters = 1'b1;
    next_cycle();
    clr_counters = 1'b0;
    mem_access = 1'b1; cache_ready = 1'b0; branch_taken = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("miss_freeze", freeze, 1);
      chk("miss_flush", flush, 0);
      chk("miss_hazard", hazard, 0);
      chk("miss_state", state, (c == 1) ? 0 : 1);
      chk("miss_stall_cnt", stall_cycles, c - 1);
      next_cycle();
    end
    cache_ready = 1'b1;
    @(negedge clk);
    chk("release_freeze", freeze, 0);
    chk("release_flush", flush, 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("after_miss_state", state, 0);
    chk("after_miss_freeze", freeze, 0);
    chk("after_miss_stall_cnt", stall_cycles, 4);

    // Watchdog: cache never answers.
    next_cycle();
    mem_access = 1'b1; cache_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("wd_freeze", freeze, 1);
      chk("wd_state", state, (c == 1) ? 0 : 1);
      chk("wd_timeout", mem_timeout, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("wd_state_error", state, 2);
    chk("wd_timeout_set", mem_timeout, 1);
    next_cycle();
    mem_access = 1'b0; cache_ready = 1'b1; branch_taken = 1'b1;
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    @(negedge clk);
    chk("err_state_held", state, 2);
    chk("err_freeze_held", freeze, 1);
    chk("err_timeout_held", mem_timeout, 1);
    chk("err_flush", flush, 0);
    chk("err_hazard", hazard, 0);
    next_cycle();
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_timeout", mem_timeout, 0);
    chk("midrst_freeze", freeze, 0);
    chk("midrst_stall_cnt", stall_cycles, 0);
    chk("midrst_hazard_cnt", hazard_cycles, 0);
    @(negedge clk);
    rst = 1'b0;

    // Hazard counter saturation and clear.
    next_cycle();
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("sat_hazard", hazard, 1);
      if (c == 10) chk("sat_cnt_mid", hazard_cycles, 9);
      next_cycle();
    end
    clr_counters = 1'b1;
    @(negedge clk);
    chk("sat_cnt", hazard_cycles, 15);
    next_cycle();
    clr_counters = 1'b0;
    @(negedge clk);
    chk("clr_cnt", hazard_cycles, 0);
    next_cycle();
    @(negedge clk);
    chk("recount", hazard_cycles, 1);
    chk("stall_idle", stall_cycles, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish before 50000");
    $fatal(1);
  end

endmodule
